mdio_responder: RTL



---
 rtl/mdio_responder.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY-side responder with a small 16-bit register file.
// Optional macro MDIO_BROADCAST_EN: PHY address 0 accepts broadcast writes.
module mdio_responder #(
  parameter int          NREG         = 8,
  parameter int          PREAMBLE_MIN = 32,
  parameter logic [15:0] REG0_RST     = 16'h1140
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         phyaddr,
  input  logic               mdc,
  input  logic               mdio_in,
  output logic               mdio_out,
  output logic               mdio_oe,
  input  logic [15:0]        status_in,
  output logic [16*NREG-1:0] regs,
  output logic               wr_strobe,
  output logic [4:0]         wr_addr,
  output logic [15:0]        wr_data
);

  typedef enum logic [3:0] {IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RTA, RDATA} state_t;

  localparam logic [5:0] NREG6    = 6'(NREG);
  localparam logic [5:0] PRE_MIN6 = 6'(PREAMBLE_MIN);

  state_t      state, state_nxt;
  logic [4:0]  bit_cnt, bit_nxt;
  logic [5:0]  pre_cnt, pre_nxt;
  logic        mdc_s1, mdc_s2, mdc_s3;
  logic        mdio_s1, mdio_s2;
  logic        rise, fall;
  logic [15:0] shift, shift_in;
  logic        is_read, hit, hit_calc;
  logic [4:0]  addr;
  logic        wr_valid, commit;
  logic [15:0] rd_word, rd_sel;
  logic [15:0] reg_q [NREG];

  assign rise     = mdc_s2 & ~mdc_s3;
  assign fall     = ~mdc_s2 & mdc_s3;
  assign shift_in = {shift[14:0], mdio_s2};
  assign wr_valid = (addr != 5'd1) && ({1'b0, addr} < NREG6);

`ifdef MDIO_BROADCAST_EN
  assign hit_calc = (shift_in[4:0] == phyaddr) || ((shift_in[4:0] == 5'd0) && !is_read);
`else
  assign hit_calc = (shift_in[4:0] == phyaddr);
`endif

  always_comb begin
    regs = '0;
    for (int k = 0; k < NREG; k++) regs[16*k +: 16] = reg_q[k];
  end

  // Read word is selected from the address being completed on this edge
  always_comb begin
    rd_sel = 16'h0000;
    if (shift_in[4:0] == 5'd1) rd_sel = status_in;
    else
      for (int k = 0; k < NREG; k++)
        if (shift_in[4:0] == 5'(k)) rd_sel = reg_q[k];
  end

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    pre_nxt   = pre_cnt;
    commit    = 1'b0;
    if (rise) begin
      case (state)
        IDLE: begin
          if (mdio_s2) begin
            if (pre_cnt != 6'd32) pre_nxt = pre_cnt + 6'd1;
          end else if (pre_cnt >= PRE_MIN6) begin
            state_nxt = ST;
            pre_nxt   = 6'd0;
          end else begin
            pre_nxt = 6'd0;
          end
        end
        ST: begin
          bit_nxt = 5'd0;
          if (mdio_s2) state_nxt = OP;
          else begin
            state_nxt = IDLE;
            pre_nxt   = 6'd0;
          end
        end
        OP: begin
          if (bit_cnt == 5'd0) bit_nxt = 5'd1;
          else if (shift_in[1:0] == 2'b01 || shift_in[1:0] == 2'b10) begin
            state_nxt = PHYAD;
            bit_nxt   = 5'd0;
          end else begin
            state_nxt = IDLE;
            pre_nxt   = 6'd0;
          end
        end
        PHYAD: begin
          if (bit_cnt == 5'd4) begin
            state_nxt = REGAD;
            bit_nxt   = 5'd0;
          end else bit_nxt = bit_cnt + 5'd1;
        end
        REGAD: begin
          if (bit_cnt == 5'd4) begin
            state_nxt = is_read ? RTA : TA;
            bit_nxt   = 5'd0;
          end else bit_nxt = bit_cnt + 5'd1;
        end
        TA: begin
          if (bit_cnt == 5'd1) begin
            state_nxt = WDATA;
            bit_nxt   = 5'd0;
          end else bit_nxt = bit_cnt + 5'd1;
        end
        WDATA: begin
          if (bit_cnt == 5'd15) begin
            state_nxt = IDLE;
            pre_nxt   = 6'd0;
            bit_nxt   = 5'd0;
            commit    = hit && wr_valid;
          end else bit_nxt = bit_cnt + 5'd1;
        end
        default: ;
      endcase
    end else if (fall) begin
      // Read turnaround and data are paced by falling edges only
      case (state)
        RTA: begin
          if (bit_cnt == 5'd0) bit_nxt = 5'd1;
          else begin
            state_nxt = RDATA;
            bit_nxt   = 5'd0;
          end
        end
        RDATA: begin
          if (bit_cnt == 5'd16) begin
            state_nxt = IDLE;
            pre_nxt   = 6'd0;
            bit_nxt   = 5'd0;
          end else bit_nxt = bit_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= 5'd0;
      pre_cnt <= 6'd0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_nxt;
      pre_cnt <= pre_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_s1    <= 1'b0;
      mdc_s2    <= 1'b0;
      mdc_s3    <= 1'b0;
      mdio_s1   <= 1'b1;
      mdio_s2   <= 1'b1;
      shift     <= 16'h0000;
      is_read   <= 1'b0;
      hit       <= 1'b0;
      addr      <= 5'd0;
      rd_word   <= 16'h0000;
      mdio_out  <= 1'b1;
      mdio_oe   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 5'd0;
      wr_data   <= 16'h0000;
      for (int k = 0; k < NREG; k++) reg_q[k] <= (k == 0) ? REG0_RST : 16'h0000;
    end else begin
      mdc_s1    <= mdc;
      mdc_s2    <= mdc_s1;
      mdc_s3    <= mdc_s2;
      mdio_s1   <= mdio_in;
      mdio_s2   <= mdio_s1;
      wr_strobe <= commit;
      if (rise) shift <= shift_in;
      if (rise && state == OP && bit_cnt == 5'd1) is_read <= (shift_in[1:0] == 2'b10);
      if (rise && state == PHYAD && bit_cnt == 5'd4) hit <= hit_calc;
      if (rise && state == REGAD && bit_cnt == 5'd4) begin
        addr <= shift_in[4:0];
        if (is_read && hit) rd_word <= rd_sel;
      end
      if (commit) begin
        wr_addr <= addr;
        wr_data <= shift_in;
        for (int k = 0; k < NREG; k++)
          if (addr == 5'(k)) reg_q[k] <= shift_in;
      end
      if (fall && hit) begin
        if (state == RTA && bit_cnt == 5'd1) begin
          mdio_oe  <= 1'b1;
          mdio_out <= 1'b0;
        end else if (state == RDATA) begin
          if (bit_cnt == 5'd16) begin
            mdio_oe  <= 1'b0;
            mdio_out <= 1'b1;
          end else begin
            mdio_out <= rd_word[15];
            rd_word  <= {rd_word[14:0], 1'b0};
          end
        end
      end
    end
  end

endmodule
